// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input arbitrated multiplexer with a registered output stage.
// Arbitration is round-robin or fixed priority. Every port uses a valid/ready
// handshake. The output register refills in the same cycle it drains.
module rr_arb_mux #(
    parameter int WIDTH      = 32,
    parameter int N          = 2,
    parameter int FIXED_PRIO = 0,
    parameter int SELW       = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_sel
);

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  ptr_nxt;
    logic [SELW-1:0]  grant;
    logic             found;
    logic             any_vld;
    logic             load;
    logic [WIDTH-1:0] data_mux;

    logic [WIDTH-1:0] data_p1;
    logic [SELW-1:0]  sel_p1;
    logic             vld_p1;

    assign any_vld = |in_valid;
    // The register may take a new word whenever it is empty or is being drained now.
    assign load    = ~vld_p1 | out_ready;
    // The pointer wraps explicitly, so N does not have to be a power of two.
    assign ptr_nxt = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);

    // Grant search: first pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    // In fixed-priority mode the first pass covers every channel from index 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i] && ((FIXED_PRIO != 0) || (SELW'(i) >= ptr))) begin
                grant = SELW'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && in_valid[i]) begin
                grant = SELW'(i);
                found = 1'b1;
            end
        end
    end

    // Accept only on the granted channel, and never while in reset or stalled.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = rst_n & load & any_vld & (grant == SELW'(i));
        end
    end

    // Select the granted channel's data for the output register.
    always_comb begin
        data_mux = '0;
        for (int i = 0; i < N; i++) begin
            if (grant == SELW'(i)) begin
                data_mux = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage p1: capture the granted word and advance the RR pointer on acceptance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            sel_p1  <= '0;
            ptr     <= '0;
        end else if (load) begin
            vld_p1 <= any_vld;
            if (any_vld) begin
                data_p1 <= data_mux;
                sel_p1  <= grant;
                if (FIXED_PRIO == 0) begin
                    ptr <= ptr_nxt;
                end
            end
        end
    end

    assign out_data  = data_p1;
    assign out_sel   = sel_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Testbench for rr_arb_mux: a vector table on a 2-channel RR instance, plus
// scoreboarded sequences on 3-channel RR, 2-channel fixed-priority and
// 4-channel RR instances.
module tb_rr_arb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Instance a: N=2, round-robin, driven from the vector table
    logic        rst_n_a;
    logic [63:0] id_a;
    logic [1:0]  iv_a, ir_a;
    logic [31:0] od_a;
    logic        ov_a, ordy_a;
    logic [0:0]  os_a;

    // Instance b: N=3, round-robin
    logic        rst_n_b;
    logic [95:0] id_b;
    logic [2:0]  iv_b, ir_b;
    logic [31:0] od_b;
    logic        ov_b, ordy_b;
    logic [1:0]  os_b;

    // Instance c: N=2, fixed priority
    logic        rst_n_c;
    logic [63:0] id_c;
    logic [1:0]  iv_c, ir_c;
    logic [31:0] od_c;
    logic        ov_c, ordy_c;
    logic [0:0]  os_c;

    // Instance d: N=4, round-robin
    logic         rst_n_d;
    logic [127:0] id_d;
    logic [3:0]   iv_d, ir_d;
    logic [31:0]  od_d;
    logic         ov_d, ordy_d;
    logic [1:0]   os_d;

    rr_arb_mux #(.WIDTH(32), .N(2), .FIXED_PRIO(0)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .in_data(id_a), .in_valid(iv_a), .in_ready(ir_a),
        .out_data(od_a), .out_valid(ov_a), .out_ready(ordy_a), .out_sel(os_a));

    rr_arb_mux #(.WIDTH(32), .N(3), .FIXED_PRIO(0)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .in_data(id_b), .in_valid(iv_b), .in_ready(ir_b),
        .out_data(od_b), .out_valid(ov_b), .out_ready(ordy_b), .out_sel(os_b));

    rr_arb_mux #(.WIDTH(32), .N(2), .FIXED_PRIO(1)) dut_c (
        .clk(clk), .rst_n(rst_n_c), .in_data(id_c), .in_valid(iv_c), .in_ready(ir_c),
        .out_data(od_c), .out_valid(ov_c), .out_ready(ordy_c), .out_sel(os_c));

    rr_arb_mux #(.WIDTH(32), .N(4), .FIXED_PRIO(0)) dut_d (
        .clk(clk), .rst_n(rst_n_d), .in_data(id_d), .in_valid(iv_d), .in_ready(ir_d),
        .out_data(od_d), .out_valid(ov_d), .out_ready(ordy_d), .out_sel(os_d));

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
    } sb_t;

    sb_t q_b[$];
    sb_t q_c[$];
    sb_t q_d[$];

    typedef struct {
        logic        rst_n;
        logic [1:0]  iv;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        ordy;
        logic [1:0]  ir;
        logic        ov;
        logic [31:0] od;
        logic        os;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_b(input logic [31:0] d, input logic [1:0] s);
        sb_t e;
        e.data = d; e.sel = s;
        q_b.push_back(e);
    endtask

    task automatic push_c(input logic [31:0] d, input logic [1:0] s);
        sb_t e;
        e.data = d; e.sel = s;
        q_c.push_back(e);
    endtask

    task automatic push_d(input logic [31:0] d, input logic [1:0] s);
        sb_t e;
        e.data = d; e.sel = s;
        q_d.push_back(e);
    endtask

    // Output monitors: a word leaves at the next edge when valid & ready outside reset.
    always @(negedge clk) begin : mon_b
        sb_t e;
        if (rst_n_b && ov_b && ordy_b) begin
            if (q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected: got data %0d sel %0d with nothing expected", od_b, os_b);
            end else begin
                e = q_b.pop_front();
                chk("b_data", od_b, e.data);
                chk("b_sel", os_b, e.sel);
            end
        end
    end

    always @(negedge clk) begin : mon_c
        sb_t e;
        if (rst_n_c && ov_c && ordy_c) begin
            if (q_c.size() == 0) begin
                total++; bad++;
                $display("FAIL c_unexpected: got data %0d sel %0d with nothing expected", od_c, os_c);
            end else begin
                e = q_c.pop_front();
                chk("c_data", od_c, e.data);
                chk("c_sel", os_c, e.sel);
            end
        end
    end

    always @(negedge clk) begin : mon_d
        sb_t e;
        if (rst_n_d && ov_d && ordy_d) begin
            if (q_d.size() == 0) begin
                total++; bad++;
                $display("FAIL d_unexpected: got data %0d sel %0d with nothing expected", od_d, os_d);
            end else begin
                e = q_d.pop_front();
                chk("d_data", od_d, e.data);
                chk("d_sel", os_d, e.sel);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] fd [3];
        // Fields: rst_n, in_valid, ch0, ch1, out_ready | in_ready before edge, out_valid/out_data/out_sel after edge
        vt[0]  = '{1'b0, 2'b11, 32'd1,  32'd2,   1'b1, 2'b00, 1'b0, 32'd0,   1'b0};
        vt[1]  = '{1'b0, 2'b11, 32'd1,  32'd2,   1'b1, 2'b00, 1'b0, 32'd0,   1'b0};
        vt[2]  = '{1'b1, 2'b01, 32'd10, 32'd20,  1'b1, 2'b01, 1'b1, 32'd10,  1'b0};
        vt[3]  = '{1'b1, 2'b10, 32'd10, 32'd675, 1'b1, 2'b10, 1'b1, 32'd675, 1'b1};
        vt[4]  = '{1'b1, 2'b11, 32'd5,  32'd6,   1'b1, 2'b01, 1'b1, 32'd5,   1'b0};
        vt[5]  = '{1'b1, 2'b11, 32'd7,  32'd8,   1'b1, 2'b10, 1'b1, 32'd8,   1'b1};
        vt[6]  = '{1'b1, 2'b00, 32'd7,  32'd8,   1'b1, 2'b00, 1'b0, 32'd8,   1'b1};
        vt[7]  = '{1'b1, 2'b10, 32'd3,  32'd9,   1'b0, 2'b10, 1'b1, 32'd9,   1'b1};
        vt[8]  = '{1'b1, 2'b01, 32'd11, 32'd12,  1'b0, 2'b00, 1'b1, 32'd9,   1'b1};
        vt[9]  = '{1'b1, 2'b01, 32'd13, 32'd12,  1'b1, 2'b01, 1'b1, 32'd13,  1'b0};
        vt[10] = '{1'b0, 2'b11, 32'd14, 32'd15,  1'b1, 2'b00, 1'b0, 32'd0,   1'b0};
        vt[11] = '{1'b1, 2'b11, 32'd21, 32'd22,  1'b1, 2'b01, 1'b1, 32'd21,  1'b0};

        rst_n_b = 1'b0; iv_b = '0; id_b = '0; ordy_b = 1'b1;
        rst_n_c = 1'b0; iv_c = '0; id_c = '0; ordy_c = 1'b1;
        rst_n_d = 1'b0; iv_d = '0; id_d = '0; ordy_d = 1'b1;

        // Vector table on instance a
        for (int k = 0; k < 12; k++) begin
            rst_n_a = vt[k].rst_n;
            iv_a    = vt[k].iv;
            id_a    = {vt[k].d1, vt[k].d0};
            ordy_a  = vt[k].ordy;
            #1;
            chk($sformatf("a_in_ready[%0d]", k), ir_a, vt[k].ir);
            step();
            chk($sformatf("a_out_valid[%0d]", k), ov_a, vt[k].ov);
            chk($sformatf("a_out_data[%0d]", k), od_a, vt[k].od);
            chk($sformatf("a_out_sel[%0d]", k), os_a, vt[k].os);
        end
        iv_a = '0;

        // Reset state of the other instances
        chk("b_reset_valid", ov_b, 0);
        chk("c_reset_valid", ov_c, 0);
        chk("d_reset_data", od_d, 0);
        rst_n_b = 1'b1; rst_n_c = 1'b1; rst_n_d = 1'b1;
        step();

        // RR fairness on 3 channels: grants 0,1,2,0,1,2
        fd[0] = 32'd12833; fd[1] = 32'd87098; fd[2] = 32'd76890;
        id_b = {fd[2], fd[1], fd[0]};
        iv_b = 3'b111;
        ordy_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("b_onehot[%0d]", k), ir_b, 3'b001 << (k % 3));
            push_b(fd[k % 3], 2'(k % 3));
            step();
        end
        iv_b = '0;
        step();
        step();

        // Backpressure: hold 134 for three stalled cycles, then drain and refill together
        iv_b = 3'b001; id_b = {32'd0, 32'd0, 32'd134};
        push_b(32'd134, 2'd0);
        step();
        ordy_b = 1'b0;
        iv_b = 3'b111;
        for (int k = 0; k < 3; k++) begin
            id_b = {32'(500 + k), 32'(600 + k), 32'(700 + k)};
            #1;
            chk($sformatf("b_stall_ready[%0d]", k), ir_b, 3'b000);
            step();
            chk($sformatf("b_stall_data[%0d]", k), od_b, 134);
            chk($sformatf("b_stall_valid[%0d]", k), ov_b, 1);
        end
        id_b = {32'd3, 32'd2, 32'd1};
        ordy_b = 1'b1;
        #1;
        chk("b_resume_ready", ir_b, 3'b010);
        push_b(32'd2, 2'd1);
        step();
        chk("b_refill_data", od_b, 2);
        chk("b_refill_sel", os_b, 1);
        iv_b = '0;
        step();
        step();

        // Fixed priority: channel 0 wins while it requests
        id_c = {32'd700000, 32'd100000};
        iv_c = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("c_prio_ready[%0d]", k), ir_c, 2'b01);
            push_c(32'd100000, 2'd0);
            step();
        end
        iv_c = 2'b10;
        #1;
        chk("c_low_ready", ir_c, 2'b10);
        push_c(32'd700000, 2'd1);
        step();
        iv_c = '0;
        step();
        step();

        // Reset mid-stream on 4 channels with ptr = 2 and a held word
        id_d = {32'd43, 32'd42, 32'd41, 32'd40};
        iv_d = 4'b0010;
        ordy_d = 1'b0;
        step();
        chk("d_held_valid", ov_d, 1);
        chk("d_held_sel", os_d, 1);
        rst_n_d = 1'b0;
        iv_d = 4'b1111;
        #1;
        chk("d_reset_ready", ir_d, 4'b0000);
        step();
        chk("d_after_reset_valid", ov_d, 0);
        chk("d_after_reset_data", od_d, 0);
        chk("d_after_reset_sel", os_d, 0);
        rst_n_d = 1'b1;
        ordy_d = 1'b1;
        #1;
        chk("d_first_grant", ir_d, 4'b0001);
        push_d(32'd40, 2'd0);
        step();
        #1;
        chk("d_second_grant", ir_d, 4'b0010);
        push_d(32'd41, 2'd1);
        step();
        iv_d = '0;
        step();
        step();

        chk("b_queue_empty", q_b.size(), 0);
        chk("c_queue_empty", q_c.size(), 0);
        chk("d_queue_empty", q_d.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
